// File: rtl/convo_result_packer.sv
//==============================================================================
// Module   : convo_result_packer
// Brief    : Packs result bytes four per word, little-endian, into a byte-enabled BRAM write port.
// Revision : 1.0
//==============================================================================
`default_nettype none

module convo_result_packer #(
    parameter int ADDR_BIT    = 9,
    parameter int BRAM_ADDR_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [BRAM_ADDR_W-1:0] base_addr,
    input  logic [2*ADDR_BIT-1:0]  total_len,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    output logic                   in_ready,
    output logic                   bram_en,
    output logic [3:0]             bram_we,
    output logic [BRAM_ADDR_W-1:0] bram_addr,
    output logic [31:0]            bram_din,
    output logic                   busy,
    output logic                   done
);

    localparam int LEN_W = 2 * ADDR_BIT;
    localparam logic [LEN_W-1:0]       c_len_one   = LEN_W'(1);
    localparam logic [LEN_W-1:0]       c_len_zero  = '0;
    localparam logic [BRAM_ADDR_W-1:0] c_word_step = BRAM_ADDR_W'(4);
    localparam logic [BRAM_ADDR_W-1:0] c_align     = {{(BRAM_ADDR_W-2){1'b1}}, 2'b00};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PACK  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [BRAM_ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]       r_remaining;
    logic [1:0]             r_lane_idx;
    logic [3:0]             r_lane_mask;
    logic [31:0]            r_pack_data;

    logic        w_accept;
    logic        w_last;
    logic        w_word_done;
    logic [3:0]  w_lane_mask;
    logic [31:0] w_pack_data;
    logic [31:0] w_lane_fill;

    assign in_ready    = (r_state == S_PACK);
    assign busy        = (r_state == S_PACK) || (r_state == S_DRAIN);
    assign done        = (r_state == S_DONE);
    assign w_accept    = in_valid && in_ready;
    assign w_last      = w_accept && (r_remaining == c_len_one);
    assign w_word_done = w_accept && ((r_lane_idx == 2'd3) || (r_remaining == c_len_one));

    always_comb begin
        w_lane_mask = r_lane_mask;
        w_pack_data = r_pack_data;
        case (r_lane_idx)
            2'd0:    begin w_pack_data[7:0]   = in_data; w_lane_mask[0] = 1'b1; end
            2'd1:    begin w_pack_data[15:8]  = in_data; w_lane_mask[1] = 1'b1; end
            2'd2:    begin w_pack_data[23:16] = in_data; w_lane_mask[2] = 1'b1; end
            default: begin w_pack_data[31:24] = in_data; w_lane_mask[3] = 1'b1; end
        endcase
        w_lane_fill = {{8{w_lane_mask[3]}}, {8{w_lane_mask[2]}},
                       {8{w_lane_mask[1]}}, {8{w_lane_mask[0]}}};
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = (total_len != c_len_zero) ? S_PACK : S_DONE;
            S_PACK:  if (w_last) w_next = S_DRAIN;
            S_DRAIN: w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_lane_idx  <= 2'd0;
            r_lane_mask <= 4'b0000;
            r_pack_data <= '0;
            bram_en     <= 1'b0;
            bram_we     <= 4'b0000;
            bram_addr   <= '0;
            bram_din    <= '0;
        end else begin
            r_state <= w_next;
            bram_en <= 1'b0;
            bram_we <= 4'b0000;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr      <= base_addr & c_align;
                        r_remaining <= total_len;
                        r_lane_idx  <= 2'd0;
                        r_lane_mask <= 4'b0000;
                        r_pack_data <= '0;
                    end
                end
                S_PACK: begin
                    if (w_accept) begin
                        r_remaining <= r_remaining - c_len_one;
                        r_lane_idx  <= r_lane_idx + 2'd1;
                        if (w_word_done) begin
                            bram_en     <= 1'b1;
                            bram_we     <= w_lane_mask;
                            bram_din    <= w_pack_data & w_lane_fill;
                            bram_addr   <= r_addr;
                            r_addr      <= r_addr + c_word_step;
                            r_lane_mask <= 4'b0000;
                            r_pack_data <= '0;
                        end else begin
                            r_lane_mask <= w_lane_mask;
                            r_pack_data <= w_pack_data;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_convo_result_packer.sv
//==============================================================================
// Module   : tb_convo_result_packer
// Brief    : Table-driven directed bench for convo_result_packer.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_convo_result_packer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic [17:0] total_len;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        bram_en;
    logic [3:0]  bram_we;
    logic [31:0] bram_addr;
    logic [31:0] bram_din;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        start;
        logic [31:0] base;
        logic [17:0] len;
        logic        valid;
        logic [7:0]  data;
        logic        rdy;
        logic        en;
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] din;
        logic        busy;
        logic        done;
    } vec_t;

    vec_t tbl[$];

    convo_result_packer #(.ADDR_BIT(9), .BRAM_ADDR_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .total_len (total_len),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .bram_en   (bram_en),
        .bram_we   (bram_we),
        .bram_addr (bram_addr),
        .bram_din  (bram_din),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input logic st, input logic [31:0] base, input logic [17:0] len,
                       input logic v, input logic [7:0] d, input logic rdy, input logic en,
                       input logic [3:0] we, input logic [31:0] addr, input logic [31:0] din,
                       input logic bsy, input logic dn);
        tbl.push_back('{st, base, len, v, d, rdy, en, we, addr, din, bsy, dn});
    endtask

    // Inputs applied at the falling edge; outputs checked 1ns after the rising edge.
    task automatic run_step(input vec_t v, input string tag);
        @(negedge clk);
        start     = v.start;
        base_addr = v.base;
        total_len = v.len;
        in_valid  = v.valid;
        in_data   = v.data;
        @(posedge clk);
        #1;
        check({tag, "/in_ready"}, {31'd0, in_ready}, {31'd0, v.rdy});
        check({tag, "/bram_en"},  {31'd0, bram_en},  {31'd0, v.en});
        check({tag, "/bram_we"},  {28'd0, bram_we},  {28'd0, v.we});
        check({tag, "/busy"},     {31'd0, busy},     {31'd0, v.busy});
        check({tag, "/done"},     {31'd0, done},     {31'd0, v.done});
        if (v.en) begin
            check({tag, "/bram_addr"}, bram_addr, v.addr);
            check({tag, "/bram_din"},  bram_din,  v.din);
        end
    endtask

    task automatic check_all_reset(input string tag);
        check({tag, "/in_ready"},  {31'd0, in_ready}, 32'd0);
        check({tag, "/bram_en"},   {31'd0, bram_en},  32'd0);
        check({tag, "/bram_we"},   {28'd0, bram_we},  32'd0);
        check({tag, "/bram_addr"}, bram_addr,         32'd0);
        check({tag, "/bram_din"},  bram_din,          32'd0);
        check({tag, "/busy"},      {31'd0, busy},     32'd0);
        check({tag, "/done"},      {31'd0, done},     32'd0);
    endtask

    task automatic step(input logic st, input logic [31:0] base, input logic [17:0] len,
                        input logic v, input logic [7:0] d, input logic rdy, input logic en,
                        input logic [3:0] we, input logic [31:0] addr, input logic [31:0] din,
                        input logic bsy, input logic dn, input string tag);
        vec_t s;
        s = '{st, base, len, v, d, rdy, en, we, addr, din, bsy, dn};
        run_step(s, tag);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = '0; total_len = '0;
        in_valid = 1'b0; in_data = '0;
        #12;
        check_all_reset("reset_init");
        @(negedge clk);
        rst = 1'b0;
        step(0, 0, 0, 0, 8'h00, 0, 0, 4'h0, 0, 0, 0, 0, "idle_nostart");

        // Full words: base 0x100, 8 bytes
        add(1, 32'h100, 18'd8, 0, 8'h00, 1, 0, 4'h0, 0, 0, 1, 0);
        add(0, 0, 0, 1, 8'h01, 1, 0, 4'h0, 0, 0, 1, 0);
        add(0, 0, 0, 1, 8'h02, 1, 0, 4'h0, 0, 0, 1, 0);
        add(0, 0, 0, 1, 8'h03, 1, 0, 4'h0, 0, 0, 1, 0);
        add(0, 0, 0, 1, 8'h04, 1, 1, 4'hF, 32'h100, 32'h04030201, 1, 0);
        add(0, 0, 0, 1, 8'h05, 1, 0, 4'h0, 0, 0, 1, 0);
        add(0, 0, 0, 1, 8'h06, 1, 0, 4'h0, 0, 0, 1, 0);
        add(0, 0, 0, 1, 8'h07, 1, 0, 4'h0, 0, 0, 1, 0);
        add(0, 0, 0, 1, 8'h08, 0, 1, 4'hF, 32'h104, 32'h08070605, 1, 0);
        add(0, 0, 0, 0, 8'h00, 0, 0, 4'h0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 8'h00, 0, 0, 4'h0, 0, 0, 0, 0);
        // Partial tail: base 0x203 aligns to 0x200, 5 bytes
        add(1, 32'h203, 18'd5, 0, 8'h00, 1, 0, 4'h0, 0, 0, 1, 0);
        add(0, 0, 0, 1, 8'hA1, 1, 0, 4'h0, 0, 0, 1, 0);
        add(0, 0, 0, 1, 8'hA2, 1, 0, 4'h0, 0, 0, 1, 0);
        add(0, 0, 0, 1, 8'hA3, 1, 0, 4'h0, 0, 0, 1, 0);
        add(0, 0, 0, 1, 8'hA4, 1, 1, 4'hF, 32'h200, 32'hA4A3A2A1, 1, 0);
        add(0, 0, 0, 1, 8'hA5, 0, 1, 4'h1, 32'h204, 32'h000000A5, 1, 0);
        add(0, 0, 0, 0, 8'h00, 0, 0, 4'h0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 8'h00, 0, 0, 4'h0, 0, 0, 0, 0);
        // Gaps in in_valid, start pulsed during PACK
        add(1, 32'h40, 18'd4, 0, 8'h00, 1, 0, 4'h0, 0, 0, 1, 0);
        add(0, 0, 0, 1, 8'hB1, 1, 0, 4'h0, 0, 0, 1, 0);
        add(1, 32'h999, 18'd3, 0, 8'h00, 1, 0, 4'h0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 8'h00, 1, 0, 4'h0, 0, 0, 1, 0);
        add(0, 0, 0, 1, 8'hB2, 1, 0, 4'h0, 0, 0, 1, 0);
        add(0, 0, 0, 1, 8'hB3, 1, 0, 4'h0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 8'h00, 1, 0, 4'h0, 0, 0, 1, 0);
        add(0, 0, 0, 1, 8'hB4, 0, 1, 4'hF, 32'h40, 32'hB4B3B2B1, 1, 0);
        add(0, 0, 0, 0, 8'h00, 0, 0, 4'h0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 8'h00, 0, 0, 4'h0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 8'h00, 0, 0, 4'h0, 0, 0, 0, 0);
        // Empty job
        add(1, 32'h80, 18'd0, 0, 8'h00, 0, 0, 4'h0, 0, 0, 0, 1);
        add(0, 0, 0, 1, 8'h77, 0, 0, 4'h0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 8'h77, 0, 0, 4'h0, 0, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            run_step(tbl[i], $sformatf("vec%0d", i));
        end

        // Asynchronous reset while a write is being presented
        step(1, 32'h500, 18'd4, 0, 8'h00, 1, 0, 4'h0, 0, 0, 1, 0, "ar_start");
        step(0, 0, 0, 1, 8'h51, 1, 0, 4'h0, 0, 0, 1, 0, "ar_b1");
        step(0, 0, 0, 1, 8'h52, 1, 0, 4'h0, 0, 0, 1, 0, "ar_b2");
        step(0, 0, 0, 1, 8'h53, 1, 0, 4'h0, 0, 0, 1, 0, "ar_b3");
        step(0, 0, 0, 1, 8'h54, 0, 1, 4'hF, 32'h500, 32'h54535251, 1, 0, "ar_b4");
        #2 rst = 1'b1;
        #1;
        check_all_reset("async_rst");
        @(negedge clk);
        rst = 1'b0;
        step(0, 0, 0, 0, 8'h00, 0, 0, 4'h0, 0, 0, 0, 0, "ar_after");

        // Reset mid-job after two bytes, then a fresh job
        step(1, 32'h300, 18'd8, 0, 8'h00, 1, 0, 4'h0, 0, 0, 1, 0, "mj_start");
        step(0, 0, 0, 1, 8'hC1, 1, 0, 4'h0, 0, 0, 1, 0, "mj_b1");
        step(0, 0, 0, 1, 8'hC2, 1, 0, 4'h0, 0, 0, 1, 0, "mj_b2");
        #2 rst = 1'b1;
        #1;
        check_all_reset("midjob_rst");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1, 8'hEE, 0, 0, 4'h0, 0, 0, 0, 0, $sformatf("mj_idle%0d", i));
        end
        step(1, 32'h0, 18'd4, 0, 8'h00, 1, 0, 4'h0, 0, 0, 1, 0, "nj_start");
        step(0, 0, 0, 1, 8'h11, 1, 0, 4'h0, 0, 0, 1, 0, "nj_b1");
        step(0, 0, 0, 1, 8'h12, 1, 0, 4'h0, 0, 0, 1, 0, "nj_b2");
        step(0, 0, 0, 1, 8'h13, 1, 0, 4'h0, 0, 0, 1, 0, "nj_b3");
        step(0, 0, 0, 1, 8'h14, 0, 1, 4'hF, 32'h0, 32'h14131211, 1, 0, "nj_b4");
        step(0, 0, 0, 0, 8'h00, 0, 0, 4'h0, 0, 0, 0, 1, "nj_done");
        step(0, 0, 0, 0, 8'h00, 0, 0, 4'h0, 0, 0, 0, 0, "nj_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/convo_result_packer.md
# convo_result_packer

Write-side counterpart of the convolution FIFO controller: where that controller reads 32-bit BRAM words and feeds bytes into the line-buffer FIFO, this block takes the byte stream leaving the convolution datapath, packs four bytes per word in little-endian order and writes the words to the result BRAM through a byte-enabled port. It generates the sequential BRAM byte addresses from a base address, handles the partial final word, and reports completion with a one-cycle `done` pulse.

## Interface
- `ADDR_BIT`, 9, row-length width of the convolution path; the byte-count width is `2*ADDR_BIT`.
- `BRAM_ADDR_W`, 32, width of the BRAM byte address.

- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  job request, sampled only in IDLE.
- `base_addr`  in  BRAM_ADDR_W  first byte address; bits [1:0] are ignored and treated as 0.
- `total_len`  in  2*ADDR_BIT  number of bytes in the job.
- `in_valid`  in  1  `in_data` valid.
- `in_data`  in  8  result byte.
- `in_ready`  out  1  block accepts a byte this cycle.
- `bram_en`  out  1  write strobe, high for one cycle per word.
- `bram_we`  out  4  byte-lane write enables.
- `bram_addr`  out  BRAM_ADDR_W  word-aligned byte address.
- `bram_din`  out  32  packed word; byte 0 in bits [7:0].
- `busy`  out  1  job in progress.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, PACK, DRAIN, DONE.
- IDLE: `in_ready`=0, `busy`=0. When `start`=1, latch `base_addr` (low 2 bits cleared) into the address register and `total_len` into the remaining-byte counter, and clear the lane index. Go to PACK if `total_len`≠0; otherwise go to DONE.
- PACK: `in_ready`=1, `busy`=1. Each accepted byte (`in_valid && in_ready`) is written into lane `lane_idx` (0..3) of the pack register. That lane's enable bit is set, `lane_idx` increments mod 4, and the remaining count decrements.
- A word is emitted when the accepted byte fills lane 3 or is the last byte of the job. At that edge the output registers load:
  - `bram_en`=1
  - `bram_we` = accumulated lane mask (1111, or 0001/0011/0111 for a partial final word)
  - `bram_din` = pack data, with unfilled lanes forced to 0
  - `bram_addr` = current address

  The address register then advances by 4, and the lane mask and pack data clear.
- If the last byte was accepted, PACK goes to DRAIN; otherwise it stays in PACK.
- DRAIN: `in_ready`=0, `busy`=1; the final write is presented. Next state is DONE.
- DONE: `done`=1, `busy`=0, `in_ready`=0. Next state is IDLE.
- `start` in PACK, DRAIN or DONE is ignored. New job parameters are sampled only in IDLE.
- The BRAM port never stalls. The block accepts back-to-back bytes at one per cycle, and gaps in `in_valid` do not change packing.
- Address arithmetic is modulo 2^BRAM_ADDR_W and wraps silently.
- Reset, at any time including mid-job, forces state IDLE and clears all outputs and internal registers. Partially packed bytes are discarded without a write.

## Timing
- Reset values: `in_ready`=0, `bram_en`=0, `bram_we`=0000, `bram_addr`=0, `bram_din`=0, `busy`=0, `done`=0.
- `in_ready` rises on the first cycle after the `start` edge.
- Write latency: `bram_en` is high in the cycle immediately following the edge that accepts the word-completing byte, for exactly one cycle. `bram_addr`, `bram_din` and `bram_we` are valid in that same cycle. In any other cycle `bram_en`=0 and `bram_we`=0000.
- Completion: if the last byte is accepted at edge k, the final write is visible in cycle k+1 (DRAIN) and `done` is high in cycle k+2. The block is back in IDLE and can sample `start` in cycle k+3.
- For `total_len`=0 with `start` at edge s, `done` is high in cycle s+1 and no write is issued.

## Test plan
- Reset: assert `rst` asynchronously between clock edges -> all outputs take their reset values immediately, before the next edge; `in_ready` stays 0 with no `start`.
- Full words: `base_addr`=0x100, `total_len`=8, bytes 01..08 back to back -> writes {0x100, 0x04030201, 1111} then {0x104, 0x08070605, 1111}; `done` two cycles after byte 08 is accepted.
- Partial tail: `base_addr`=0x203 (treated as 0x200), `total_len`=5, bytes A1..A5 -> writes {0x200, 0xA4A3A2A1, 1111} then {0x204, 0x000000A5, 0001}; then `done`.
- Gaps and ignored start: `total_len`=4, `in_valid` toggled 1,0,0,1,1,0,1, `start` pulsed during PACK -> exactly one write, din 0x[b4 b3 b2 b1], we 1111; the second `start` has no effect; one `done` pulse.
- Empty job: `total_len`=0 -> `bram_en` never asserts; `done`=1 in the cycle after `start`; `in_ready` stays 0.
- Reset mid-job: after 2 of 8 bytes accepted, pulse `rst` -> no write occurs and outputs reset; a new job with `base_addr`=0x0, `total_len`=4 then writes {0x0, packed word, 1111} with no leftover bytes from the aborted job.
